// File: rtl/mac_div_pkg.sv
// Shared definitions for the accumulator-result divider.
package mac_div_pkg;
    localparam int DEF_DW = 36;
    localparam int DEF_VW = 16;
    localparam int CW     = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mac_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract,
// keep or restore. Purely combinational.
module div_step #(
    parameter int VW = 16
) (
    input  logic [VW:0]   prem,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   prem_next,
    output logic          q_bit
);
    logic [VW+1:0] shifted;
    logic [VW+1:0] diff;

    assign shifted   = {prem, bit_in};
    assign diff      = shifted - {2'b00, divisor};
    // No borrow out of the trial subtract means the divisor fits.
    assign q_bit     = ~diff[VW+1];
    assign prem_next = q_bit ? diff[VW:0] : shifted[VW:0];
endmodule

// File: rtl/mac_divider.sv
// Iterative restoring divider for accumulator results (start/busy/done).
// Optional two's-complement operation is enabled by defining SIGNED_DIV_EN.
module mac_divider
    import mac_div_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);
    state_t        state, state_next;
    logic [CW-1:0] count;
    logic [DW-1:0] shreg;
    logic [VW-1:0] dvs;
    logic [VW:0]   prem, prem_next;
    logic          q_bit;
    logic [DW-1:0] dvd_in, q_fin;
    logic [VW-1:0] dvs_in, r_fin;
    logic          dvs_zero, last;

    assign dvs_zero = (divisor == '0);
    assign last     = (count == CW'(1));

`ifdef SIGNED_DIV_EN
    logic neg_q, neg_r;
    // Feed magnitudes to the unsigned core; signs are reapplied at completion.
    always_comb begin
        dvd_in = dividend[DW-1] ? -dividend : dividend;
        dvs_in = divisor[VW-1]  ? -divisor  : divisor;
        q_fin  = neg_q ? -{shreg[DW-2:0], q_bit} : {shreg[DW-2:0], q_bit};
        r_fin  = neg_r ? -prem_next[VW-1:0] : prem_next[VW-1:0];
    end

    // Remember operand signs at acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            neg_q <= dividend[DW-1] ^ divisor[VW-1];
            neg_r <= dividend[DW-1];
        end
    end
`else
    // Unsigned: operands and results pass straight through.
    always_comb begin
        dvd_in = dividend;
        dvs_in = divisor;
        q_fin  = {shreg[DW-2:0], q_bit};
        r_fin  = prem_next[VW-1:0];
    end
`endif

    div_step #(.VW(VW)) u_step (
        .prem      (prem),
        .bit_in    (shreg[DW-1]),
        .divisor   (dvs),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: if (start) state_next = dvs_zero ? ST_DONE : ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    // Quotient bits shift into the LSB of the dividend shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count       <= '0;
            shreg       <= '0;
            dvs         <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    shreg       <= dvd_in;
                    dvs         <= dvs_in;
                    prem        <= '0;
                    count       <= CW'(DW);
                    div_by_zero <= dvs_zero;
                    if (dvs_zero) begin
                        quotient  <= '1;
                        remainder <= dividend[VW-1:0];
                    end
                end
                ST_RUN: begin
                    shreg <= {shreg[DW-2:0], q_bit};
                    prem  <= prem_next;
                    count <= count - CW'(1);
                    if (last) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_divider.sv
// Self-checking bench for mac_divider: directed cases plus random operands
// against an arithmetic reference model.
module tb_mac_divider;
    localparam int DW = 36;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    int n_cmp = 0;
    int n_err = 0;

    mac_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division from the operand rules.
    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output logic z);
`ifdef SIGNED_DIV_EN
        longint sa, sb;
`endif
        if (b == '0) begin
            q = '1;
            r = a[VW-1:0];
            z = 1'b1;
        end else begin
`ifdef SIGNED_DIV_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = DW'(sa / sb);
            r  = VW'(sa % sb);
`else
            q  = a / {{(DW-VW){1'b0}}, b};
            r  = VW'(a % {{(DW-VW){1'b0}}, b});
`endif
            z = 1'b0;
        end
    endfunction

    // Issue one division; optionally pulse a second start at cycle inj.
    task automatic do_div(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ez,
                          input int inj);
        int n, nb;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            if (n == inj) begin
                start = 1'b1; dividend = 36'd50; divisor = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(n), (b == '0) ? 64'd0 : 64'(DW));
        chk({tag, "_busycyc"}, 64'(nb), (b == '0) ? 64'd0 : 64'(DW));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_q"}, 64'(quotient), 64'(eq));
        chk({tag, "_r"}, 64'(remainder), 64'(er));
        chk({tag, "_dz"}, 64'(div_by_zero), 64'(ez));
        // A start during DONE must be ignored.
        start = 1'b1; dividend = 36'd9; divisor = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle_after"}, 64'(busy), 64'd0);
        chk({tag, "_q_held"}, 64'(quotient), 64'(eq));
    endtask

    initial begin
        logic [DW-1:0] a, eq;
        logic [VW-1:0] b, er;
        logic          ez;
        int            n, nd;

        reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_q", 64'(quotient), 64'd0);
        chk("rst_r", 64'(remainder), 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

`ifdef SIGNED_DIV_EN
        do_div("s_neg_dvd", DW'(-100), 16'd7, DW'(-14), VW'(-2), 1'b0, -1);
        do_div("s_neg_dvs", 36'd100, VW'(-7), DW'(-14), 16'd2, 1'b0, -1);
        do_div("s_ovf", 36'h8_0000_0000, 16'hFFFF, 36'h8_0000_0000, 16'd0, 1'b0, -1);
`else
        do_div("u_1000_7", 36'd1000, 16'd7, 36'd142, 16'd6, 1'b0, -1);
        do_div("u_max", 36'hF_FFFF_FFFF, 16'hFFFF, 36'h0_0010_0010, 16'd15, 1'b0, -1);
        do_div("u_ignore", 36'd1000, 16'd7, 36'd142, 16'd6, 1'b0, 10);
`endif
        do_div("dz", 36'd5, 16'd0, 36'hF_FFFF_FFFF, 16'd5, 1'b1, -1);

        // Reset in the middle of a division aborts it silently.
        start = 1'b1; dividend = 36'd777; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_q", 64'(quotient), 64'd0);
        chk("mid_rst_r", 64'(remainder), 64'd0);
        chk("mid_rst_dz", 64'(div_by_zero), 64'd0);
        reset = 1'b1;
        nd = 0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("mid_rst_no_done", 64'(nd), 64'd0);
        do_div("after_rst", 36'd12, 16'd4, 36'd3, 16'd0, 1'b0, -1);

        // Random operands, including zero and all-ones divisors.
        for (int i = 0; i < 24; i++) begin
            a = {4'($urandom_range(0, 15)), 32'($urandom)};
            case (i % 6)
                0:       b = 16'd0;
                1:       b = 16'hFFFF;
                2:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            if (i % 8 == 7) a = 36'($urandom_range(0, 200));
            model(a, b, eq, er, ez);
            do_div("rand", a, b, eq, er, ez, (i % 5 == 0) ? 5 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
